// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl
// Purpose  : Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
//            Owns the program counter, instruction register, register-file
//            and ALU strobes, and the data-memory request/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl #(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter logic [7:0] ACK_TIMEOUT = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ins,
  input  logic        dm_ack,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  output logic [2:0]  rf_waddr,
  output logic        rf_we,
  output logic        alu_src_imm,
  output logic        wb_sel,
  output logic        dm_req,
  output logic        dm_we,
  output logic [8:0]  dm_addr,
  output logic        halted,
  output logic [1:0]  err
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_IADD = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [15:0] ir_q;
  logic [1:0]  err_q;
  logic [7:0]  cnt_q;
  logic        rf_we_q;
  logic        alu_src_imm_q;
  logic        wb_sel_q;
  logic        dm_req_q;
  logic        dm_we_q;

  logic [3:0]  op;
  logic [7:0]  pc_inc_d;
  logic [8:0]  cnt_inc_d;
  logic        timeout_d;

  // Opcode of the latched instruction, next pc and the un-acked MEM cycle test.
  // The counter is widened by one bit so ACK_TIMEOUT=255 cannot wrap.
  assign op        = ir_q[15:12];
  assign pc_inc_d  = pc_q + 8'd1;
  assign cnt_inc_d = {1'b0, cnt_q} + 9'd1;
  assign timeout_d = (cnt_inc_d == {1'b0, ACK_TIMEOUT});

  // Sequencer: strobes are registered and raised on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RESET;
      ir_q          <= 16'h0000;
      err_q         <= ERR_NONE;
      cnt_q         <= 8'd0;
      rf_we_q       <= 1'b0;
      alu_src_imm_q <= 1'b0;
      wb_sel_q      <= 1'b0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
    end else begin
      rf_we_q       <= 1'b0;
      alu_src_imm_q <= 1'b0;
      wb_sel_q      <= 1'b0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          ir_q    <= ins;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_ADD, OP_IADD: begin
              state_q       <= S_EXEC;
              rf_we_q       <= 1'b1;
              alu_src_imm_q <= (op == OP_IADD);
            end
            OP_ST, OP_LD: begin
              state_q  <= S_MEM;
              cnt_q    <= 8'd0;
              dm_req_q <= 1'b1;
              dm_we_q  <= (op == OP_ST);
            end
            OP_HALT: begin
              state_q <= S_HALT;
              err_q   <= ERR_NONE;
            end
            default: begin
              state_q <= S_HALT;
              err_q   <= ERR_ILLEGAL;
            end
          endcase
        end
        S_EXEC: begin
          pc_q    <= pc_inc_d;
          state_q <= S_FETCH;
        end
        S_MEM: begin
          // An ack arriving on the final allowed cycle still completes the access.
          if (dm_ack) begin
            if (op == OP_ST) begin
              pc_q    <= pc_inc_d;
              state_q <= S_FETCH;
            end else begin
              state_q  <= S_WB;
              rf_we_q  <= 1'b1;
              wb_sel_q <= 1'b1;
            end
          end else if (timeout_d) begin
            state_q <= S_HALT;
            err_q   <= ERR_TIMEOUT;
          end else begin
            cnt_q    <= cnt_inc_d[7:0];
            dm_req_q <= 1'b1;
            dm_we_q  <= dm_we_q;
          end
        end
        S_WB: begin
          pc_q    <= pc_inc_d;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign rf_raddr_a  = ir_q[11:9];
  assign rf_raddr_b  = ir_q[8:6];
  assign rf_waddr    = ir_q[11:9];
  assign dm_addr     = ir_q[8:0];
  assign rf_we       = rf_we_q;
  assign alu_src_imm = alu_src_imm_q;
  assign wb_sel      = wb_sel_q;
  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl
// Purpose  : Self-checking bench for cpu_ctrl. Each instruction is expanded
//            into its expected per-cycle output trace from the ISA timing
//            rules and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;

  localparam logic [7:0] PC_RST = 8'h00;
  localparam logic [7:0] ACK_TO = 8'd15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        dm_ack = 1'b0;
  logic [15:0] ins;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we, alu_src_imm, wb_sel, dm_req, dm_we, halted;
  logic [8:0]  dm_addr;
  logic [1:0]  err;

  logic [15:0] imem [256];
  logic [7:0]  pc_m;
  int          vectors = 0;
  int          miscompares = 0;

  cpu_ctrl #(.PC_RESET(PC_RST), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .run(run), .ins(ins), .dm_ack(dm_ack),
    .pc(pc), .ir(ir), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_waddr(rf_waddr), .rf_we(rf_we), .alu_src_imm(alu_src_imm),
    .wb_sel(wb_sel), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .halted(halted), .err(err)
  );

  assign ins = imem[pc];

  always #5 clk = ~clk;

  // Observed control word: {pc, rf_we, alu_src_imm, wb_sel, dm_req, dm_we, halted, err}
  function automatic logic [15:0] pack_obs();
    return {pc, rf_we, alu_src_imm, wb_sel, dm_req, dm_we, halted, err};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; dm_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pc_m = PC_RST;
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle.
  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
  endtask

  // Execute the instruction at pc_m. k = ack cycle within MEM (1-based), 0 = never ack.
  task automatic step_instr(input string tag, input int k);
    logic [15:0] q[$];
    logic [15:0] w;
    logic [3:0]  op;
    logic [7:0]  p;
    logic [33:0] dexp;
    int          kk;
    bit          is_mem, halts;
    logic [1:0]  herr;
    p = pc_m; w = imem[p]; op = w[15:12];
    is_mem = (op == 4'h2) || (op == 4'h3);
    kk = (k == 0) ? int'(ACK_TO) : k;
    halts = 1'b0; herr = 2'b00;
    dexp = {w, w[11:9], w[8:6], w[11:9], w[8:0]};
    q.push_back({p, 8'h00});
    q.push_back({p, 8'h00});
    if (op == 4'h0 || op == 4'h1) begin
      q.push_back({p, 1'b1, (op == 4'h1), 4'b0000, 2'b00});
    end else if (is_mem) begin
      for (int j = 0; j < kk; j++) q.push_back({p, 3'b000, 1'b1, (op == 4'h2), 1'b0, 2'b00});
      if (k == 0) begin
        halts = 1'b1; herr = 2'b10;
      end else if (op == 4'h3) begin
        q.push_back({p, 1'b1, 1'b0, 1'b1, 3'b000, 2'b00});
      end
    end else begin
      halts = 1'b1;
      herr = (op == 4'hF) ? 2'b00 : 2'b01;
    end
    foreach (q[i]) begin
      if (is_mem && i >= 2 && i < 2 + kk) dm_ack = (k != 0) && (i == 1 + k);
      else dm_ack = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      vectors++;
      if (pack_obs() !== q[i]) begin
        miscompares++;
        $display("FAIL %s ctrl cycle %0d instr %o: got %h required %h", tag, i, w, pack_obs(), q[i]);
      end
      if (i >= 1) begin
        vectors++;
        if ({ir, rf_raddr_a, rf_raddr_b, rf_waddr, dm_addr} !== dexp) begin
          miscompares++;
          $display("FAIL %s decode cycle %0d: got %h required %h", tag, i,
                   {ir, rf_raddr_a, rf_raddr_b, rf_waddr, dm_addr}, dexp);
        end
      end
      @(negedge clk);
    end
    if (halts) begin
      for (int j = 0; j < 3; j++) begin
        dm_ack = 1'($urandom_range(0, 1));
        run = 1'($urandom_range(0, 1));
        vectors++;
        if (pack_obs() !== {p, 5'b00000, 1'b1, herr} || ir !== w) begin
          miscompares++;
          $display("FAIL %s halt cycle %0d: got %h/%h required %h/%h", tag, j, pack_obs(), ir,
                   {p, 5'b00000, 1'b1, herr}, w);
        end
        @(negedge clk);
      end
    end else begin
      pc_m = p + 8'd1;
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_reset();
    imem[0] = 16'o001200; imem[1] = 16'o011001;
    imem[2] = 16'o021002; imem[3] = 16'o031003;
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      dm_ack = 1'($urandom_range(0, 1));
      vectors++;
      if (pack_obs() !== {PC_RST, 8'h00} || ir !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: got %h/%h required %h/0000", j, pack_obs(), ir, {PC_RST, 8'h00});
      end
      @(negedge clk);
    end
    dm_ack = 1'b0;
    start_run();
  endtask

  task automatic test_alu();
    step_instr("alu_add", 1);
    step_instr("alu_iadd", 1);
  endtask

  task automatic test_mem();
    step_instr("mem_st", 3);
    step_instr("mem_ld", 3);
  endtask

  task automatic test_timeout();
    apply_reset();
    imem[0] = 16'o031003; imem[1] = 16'o001200;
    start_run();
    step_instr("timeout", 0);
    apply_reset();
    start_run();
    step_instr("ack_last", int'(ACK_TO));
    step_instr("after_ack_last", 1);
  endtask

  task automatic test_halt();
    apply_reset();
    imem[0] = 16'o170000;
    start_run();
    step_instr("halt", 1);
    apply_reset();
    imem[0] = 16'o050000;
    start_run();
    step_instr("illegal", 1);
    for (int j = 0; j < 3; j++) begin
      apply_reset();
      imem[0] = {4'($urandom_range(4, 14)), 12'($urandom)};
      start_run();
      step_instr("illegal_rand", 1);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    imem[0] = 16'o021002;
    start_run();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (dm_req !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre dm_req: got %b required 1", dm_req);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({dm_req, dm_we, pc, ir} !== {2'b00, PC_RST, 16'h0000}) begin
      miscompares++;
      $display("FAIL async_reset: got %h required %h", {dm_req, dm_we, pc, ir}, {2'b00, PC_RST, 16'h0000});
    end
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    vectors++;
    if (pack_obs() !== {PC_RST, 8'h00} || ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_idle: got %h/%h required %h/0000", pack_obs(), ir, {PC_RST, 8'h00});
    end
  endtask

  // Long random program of legal instructions; runs past 256 so pc wraps FF -> 00.
  task automatic test_random();
    apply_reset();
    for (int a = 0; a < 256; a++) imem[a] = {2'b00, 2'($urandom_range(0, 3)), 12'($urandom)};
    start_run();
    for (int n = 0; n < 300; n++) step_instr("random", int'($urandom_range(1, 4)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
    pc_m = PC_RST;
    test_reset();
    test_alu();
    test_mem();
    test_timeout();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 16-bit octal-encoded CPU. It sequences fetch/decode/execute and drives the program counter, which addresses the 256-word instruction memory. It also drives register-file and ALU control strobes and a request/acknowledge handshake to data memory. It sits between the instruction memory and the datapath and owns all architectural sequencing.

## Interface
Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- ACK_TIMEOUT, 8'd15, consecutive MEM cycles without dm_ack before fault halt (legal 1..255).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; leaves IDLE when sampled 1.
- ins  in  16  instruction word from instruction memory (combinational read of pc).
- dm_ack  in  1  data-memory completion for the current request.
- pc  out  8  instruction address.
- ir  out  16  latched instruction register.
- rf_raddr_a  out  3  = ir[11:9] (rd).
- rf_raddr_b  out  3  = ir[8:6] (rs).
- rf_waddr  out  3  = ir[11:9].
- rf_we  out  1  register-file write strobe.
- alu_src_imm  out  1  ALU B operand = zero-extended ir[8:0].
- wb_sel  out  1  0 = ALU result, 1 = data-memory read data.
- dm_req  out  1  data-memory request.
- dm_we  out  1  data-memory write qualifier (valid with dm_req).
- dm_addr  out  9  = ir[8:0].
- halted  out  1  controller in HALT.
- err  out  2  00 none / normal halt, 01 illegal opcode, 10 dm_ack timeout.

## Operation
- Encoding: op = ir[15:12], rd = ir[11:9], rs = ir[8:6], imm = ir[8:0].
- op 0 add (rd ← rd+rs); op 1 iadd (rd ← rd+imm); op 2 st (mem[imm] ← rd); op 3 ld (rd ← mem[imm]); op 4'hF halt; all others illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: outputs inactive; → FETCH when run=1.
- FETCH: ir ← ins; → DECODE.
- DECODE: add/iadd → EXEC; st/ld → MEM, timeout counter cleared; halt → HALT, err=00; illegal → HALT, err=01.
- EXEC: rf_we=1, wb_sel=0, alu_src_imm=(op==1); pc ← pc+1; → FETCH.
- MEM: dm_req=1, dm_we=(op==2). On dm_ack, st does pc ← pc+1 → FETCH, and ld → WB. Without ack the counter increments; on the ACK_TIMEOUT-th consecutive un-acked MEM cycle → HALT, err=10. Ack in that same cycle wins.
- WB: rf_we=1, wb_sel=1; pc ← pc+1; → FETCH.
- HALT: halted=1, all strobes 0, pc/ir/err frozen; exits only via rst.
- pc arithmetic is 8-bit modulo: 8'hFF+1 → 8'h00, no flag.
- rf_raddr_*, rf_waddr, dm_addr decode continuously from ir. Strobes (rf_we, dm_req, dm_we, wb_sel, alu_src_imm) are 0 outside the states listed.

## Timing
- Reset (asynchronous, immediate): state=IDLE, pc=PC_RESET, ir=16'h0000, err=00, halted=0, counter=0, all strobes 0. A mid-request reset drops dm_req combinationally, with no completion.
- Cycles per instruction: add/iadd 3; st 2+k; ld 3+k; k = MEM cycles until ack (min 1, ack in first MEM cycle).
- ins is sampled only at the end of FETCH. pc is stable from FETCH entry until the increment edge.
- dm_req/dm_we/dm_addr are held constant for all MEM cycles of one instruction. dm_ack is ignored outside MEM.
- rf_we is a single-cycle pulse per add/iadd/ld. There is exactly one pc increment per retired instruction.
- run is ignored outside IDLE. Deasserting run mid-program has no effect.

## Test plan
- Reset/idle: hold rst, release with run=0 for 5 cycles → pc=00, ir=0000, state IDLE, all strobes 0. Set run=1 → FETCH next cycle.
- ALU sequence: ins=16'o001200 then 16'o011001 → rf_we pulses in cycles 3 and 6 with rf_waddr=1. alu_src_imm=0 then 1. pc 00→01→02.
- Memory ops, ack after 3 cycles: 16'o021002 → dm_req high 3 cycles, dm_we=1, dm_addr=9'o002, no rf_we. 16'o031003 → dm_we=0, then WB with rf_we=1, wb_sel=1, rf_waddr=1.
- Timeout: ld with dm_ack stuck 0, ACK_TIMEOUT=15 → HALT after 15 MEM cycles, err=10, halted=1, pc unchanged. Repeat with ack on cycle 15 → no fault.
- Halt/illegal: 16'o170000 → halted, err=00. 16'o050000 → halted, err=01. pc frozen; rst exits.
- Wrap and async reset: PC_RESET=8'hFF, add at FF → pc=00. Assert rst mid-MEM → dm_req 0 before the next edge, state IDLE.
